// File: rtl/csum_pkg.sv
// Shared types and constants for the Internet checksum accumulator
// (state encoding, carry-save pair, word geometry and fold widths).
package csum_pkg;

    localparam int CSUM_WORDS    = 8;
    localparam int WORD_W        = 16;
    localparam int DATA_W        = CSUM_WORDS * WORD_W;
    localparam int KEEP_W        = DATA_W / 8;
    localparam int ACC_W         = 32;
    localparam int FOLD_W        = 16;
    localparam int FOLD_SUM_W    = FOLD_W + 1;
    localparam int MAX_BEATS_DEF = 4096;

    typedef enum logic [2:0] {
        ST_ACC,
        ST_DRAIN,
        ST_CPA,
        ST_FOLD,
        ST_OUT
    } csum_state_t;

    // Redundant value = sum + (carry << 1), mod 2^ACC_W
    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [ACC_W-1:0] carry;
    } csa_pair_t;

    function automatic logic [DATA_W-1:0] mask_bytes(
        input logic [DATA_W-1:0] data,
        input logic [KEEP_W-1:0] keep
    );
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            m[8*b +: 8] = keep[b] ? data[8*b +: 8] : 8'h00;
        end
        return m;
    endfunction

    // Word 0 is the most significant 16 bits (first on the wire)
    function automatic logic [ACC_W-1:0] word_ext(
        input logic [DATA_W-1:0] data,
        input int                idx
    );
        return {{(ACC_W-WORD_W){1'b0}}, data[DATA_W-1-WORD_W*idx -: WORD_W]};
    endfunction

endpackage

// File: rtl/csa_32x4.sv
// 32-bit 4:2 carry-save compressor: a+b+c+d == o_sum + (o_carry << 1) mod 2^32.
// Purely combinational; no carry-propagate path.
module csa_32x4 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    output logic [31:0] o_sum,
    output logic [31:0] o_carry
);

    logic [31:0] w_s0;
    logic [31:0] w_c0;
    logic [31:0] w_x;

    assign w_s0    = i_a ^ i_b ^ i_c;
    assign w_c0    = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign w_x     = w_c0 << 1;
    assign o_sum   = w_s0 ^ w_x ^ i_d;
    assign o_carry = (w_s0 & w_x) | (w_s0 & i_d) | (w_x & i_d);

endmodule

// File: rtl/csum_fold.sv
// Resolves the carry-save accumulator (CPA cycle) then end-around folds to 16 bits
// and inverts (FOLD cycle); each step is one registered stage gated by its enable.
module csum_fold
    import csum_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cpa_en,
    input  logic              i_fold_en,
    input  csa_pair_t         i_acc,
    output logic [FOLD_W-1:0] o_csum
);

    logic [ACC_W-1:0]      r_s;
    logic [ACC_W-1:0]      w_s_nxt;
    logic [FOLD_SUM_W-1:0] w_f1;
    logic [FOLD_W-1:0]     w_f2;
    logic [FOLD_W-1:0]     r_csum;

    assign w_s_nxt = i_acc.sum + (i_acc.carry << 1);
    assign w_f1    = {1'b0, r_s[ACC_W-1 -: FOLD_W]} + {1'b0, r_s[FOLD_W-1:0]};
    // f1 is at most 0x1FFFE, so a single end-around add cannot carry again
    assign w_f2    = w_f1[FOLD_W-1:0] + {{(FOLD_W-1){1'b0}}, w_f1[FOLD_W]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s    <= '0;
            r_csum <= '0;
        end else begin
            if (i_cpa_en) begin
                r_s <= w_s_nxt;
            end
            if (i_fold_en) begin
                r_csum <= ~w_f2;
            end
        end
    end

    assign o_csum = r_csum;

endmodule

// File: rtl/csum_accum.sv
// Streaming 128-bit ones-complement checksum; result valid 4 cycles after in_last, held until out_ready.
// in_ready drops after in_last until the result handshakes. CSUM_ACCUM_SEED_EN adds the in_seed port.
module csum_accum
    import csum_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
`ifdef CSUM_ACCUM_SEED_EN
    input  logic [WORD_W-1:0] in_seed,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FOLD_W-1:0] out_csum
);

    if (longint'(MAX_BEATS) * longint'(CSUM_WORDS + 1) * 64'd65535 >= 64'h1_0000_0000
        || MAX_BEATS < 1) begin : g_max_beats_chk
        $error("MAX_BEATS outside the exact range of a 32-bit accumulator");
    end

    csum_state_t       r_state;
    csum_state_t       w_state_nxt;
    logic              w_in_rdy;
    logic              w_out_vld;
    logic              w_cpa_en;
    logic              w_fold_en;
    logic              w_clr;
    logic              w_accept;

    logic [DATA_W-1:0] w_masked;
    logic [ACC_W-1:0]  w_word [CSUM_WORDS];
    csa_pair_t         w_grp_a;
    csa_pair_t         w_grp_b;
    csa_pair_t         w_s1_nxt;
    csa_pair_t         w_acc_nxt;
    csa_pair_t         r_s1;
    csa_pair_t         r_acc;
    logic              r_s1_vld;
    logic [ACC_W-1:0]  w_acc_base;

    assign in_ready  = w_in_rdy & ~reset;
    assign w_accept  = in_valid & in_ready;
    assign out_valid = w_out_vld;

    always_comb begin
        w_masked = mask_bytes(in_data, in_keep);
        for (int k = 0; k < CSUM_WORDS; k++) begin
            w_word[k] = word_ext(w_masked, k);
        end
    end

    csa_32x4 u_csa_lo (
        .i_a     (w_word[0]),
        .i_b     (w_word[1]),
        .i_c     (w_word[2]),
        .i_d     (w_word[3]),
        .o_sum   (w_grp_a.sum),
        .o_carry (w_grp_a.carry)
    );

    csa_32x4 u_csa_hi (
        .i_a     (w_word[4]),
        .i_b     (w_word[5]),
        .i_c     (w_word[6]),
        .i_d     (w_word[7]),
        .o_sum   (w_grp_b.sum),
        .o_carry (w_grp_b.carry)
    );

    csa_32x4 u_csa_mix (
        .i_a     (w_grp_a.sum),
        .i_b     (w_grp_a.carry << 1),
        .i_c     (w_grp_b.sum),
        .i_d     (w_grp_b.carry << 1),
        .o_sum   (w_s1_nxt.sum),
        .o_carry (w_s1_nxt.carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else if (w_clr) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1 <= w_s1_nxt;
            end
        end
    end

`ifdef CSUM_ACCUM_SEED_EN
    logic              r_first;
    logic              r_s1_first;
    logic [WORD_W-1:0] r_s1_seed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first    <= 1'b1;
            r_s1_first <= 1'b0;
            r_s1_seed  <= '0;
        end else if (w_clr) begin
            r_first    <= 1'b1;
            r_s1_first <= 1'b0;
            r_s1_seed  <= '0;
        end else begin
            r_s1_first <= w_accept & r_first;
            if (w_accept) begin
                r_first   <= 1'b0;
                r_s1_seed <= in_seed;
            end
        end
    end

    // Accumulator is zero on a packet's first beat, so its sum slot carries the seed
    assign w_acc_base = r_s1_first ? {{(ACC_W-WORD_W){1'b0}}, r_s1_seed} : r_acc.sum;
`else
    assign w_acc_base = r_acc.sum;
`endif

    csa_32x4 u_csa_acc (
        .i_a     (w_acc_base),
        .i_b     (r_acc.carry << 1),
        .i_c     (r_s1.sum),
        .i_d     (r_s1.carry << 1),
        .o_sum   (w_acc_nxt.sum),
        .o_carry (w_acc_nxt.carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_clr) begin
            r_acc <= '0;
        end else if (r_s1_vld) begin
            r_acc <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN lets the last S1 pair land in the accumulator before the CPA reads it
    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = 1'b0;
        w_out_vld   = 1'b0;
        w_cpa_en    = 1'b0;
        w_fold_en   = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_in_rdy = 1'b1;
                if (w_accept && in_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_CPA;
            end
            ST_CPA: begin
                w_cpa_en    = 1'b1;
                w_state_nxt = ST_FOLD;
            end
            ST_FOLD: begin
                w_fold_en   = 1'b1;
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                w_out_vld = 1'b1;
                if (out_ready) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_ACC;
                end
            end
            default: begin
                w_state_nxt = ST_ACC;
            end
        endcase
    end

    csum_fold u_fold (
        .clk       (clk),
        .reset     (reset),
        .i_cpa_en  (w_cpa_en),
        .i_fold_en (w_fold_en),
        .i_acc     (r_acc),
        .o_csum    (out_csum)
    );

endmodule

// File: tb/tb_csum_accum.sv
// Scoreboard bench for csum_accum: driver pushes expected checksums, an
// independent monitor pops and compares on every output handshake.
module tb_csum_accum;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [15:0]  in_keep = '0;
    logic         in_last = 1'b0;
`ifdef CSUM_ACCUM_SEED_EN
    logic [15:0]  in_seed = '0;
`endif
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_csum;

    typedef struct {
        logic [15:0] csum;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   hold_lo = 1'b0;

    csum_accum dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
`ifdef CSUM_ACCUM_SEED_EN
        .in_seed   (in_seed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_csum  (out_csum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain 16-bit word sum in wide arithmetic, then ones-complement fold
    function automatic longint unsigned beat_sum(input logic [127:0] d, input logic [15:0] k);
        longint unsigned s;
        logic [7:0]      by;
        s = 0;
        for (int j = 0; j < 16; j++) begin
            by = k[15-j] ? d[127-8*j -: 8] : 8'h00;
            s += ((j % 2) == 0) ? (longint'(by) << 8) : longint'(by);
        end
        return s;
    endfunction

    function automatic logic [15:0] ones_fold(input longint unsigned s);
        longint unsigned t;
        t = s;
        while ((t >> 16) != 0) t = (t & 64'hFFFF) + (t >> 16);
        return ~t[15:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_lo ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: handshakes, latency, stall stability, ready behaviour
    initial begin
        logic        prev_vld;
        logic        prev_stall;
        logic        rdy_next;
        logic [15:0] prev_csum;
        exp_t        e;
        prev_vld = 1'b0; prev_stall = 1'b0; rdy_next = 1'b0; prev_csum = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_vld = 1'b0; prev_stall = 1'b0; rdy_next = 1'b0;
            end else begin
                if (rdy_next) chk("rdy_after_hs", in_ready, 1);
                rdy_next = 1'b0;
                if (prev_stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_csum", out_csum, prev_csum);
                    chk("hold_in_ready", in_ready, 0);
                end
                if (out_valid && !prev_vld) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out: out_valid with csum 0x%0h, none expected", out_csum);
                    end else begin
                        chk("latency", cyc, exp_q[0].cyc + 4);
                        chk("rdy_in_out", in_ready, 0);
                    end
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("csum", out_csum, e.csum);
                    rdy_next = 1'b1;
                end
                prev_stall = out_valid && !out_ready;
                prev_csum  = out_csum;
                prev_vld   = out_valid;
            end
        end
    end

    task automatic drive_beat(input logic [127:0] d, input logic [15:0] k, input logic l, output int acc_cyc);
        int  n;
        logic ok;
        n = 0; ok = 1'b0; acc_cyc = 0;
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        do begin
            @(negedge clk);
            ok = in_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 300);
        if (!ok) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_one(input logic [127:0] d, input logic [15:0] k, input logic [15:0] exp_csum);
        int ac;
`ifdef CSUM_ACCUM_SEED_EN
        in_seed = '0;
`endif
        drive_beat(d, k, 1'b1, ac);
        exp_q.push_back('{exp_csum, ac});
    endtask

    task automatic send_pkt(input int nbeats, input int kind, input logic [15:0] seed,
                            input bit term, input bit use_lit, input logic [15:0] lit);
        longint unsigned s;
        logic [127:0]    d;
        logic [15:0]     k;
        int              ac;
        s = 0;
`ifdef CSUM_ACCUM_SEED_EN
        in_seed = seed;
        s = longint'(seed);
`endif
        for (int b = 0; b < nbeats; b++) begin
            if (kind == 1) begin
                d = '1; k = '1;
            end else begin
                d = {$urandom, $urandom, $urandom, $urandom};
                k = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom);
            end
            s += beat_sum(d, k);
            drive_beat(d, k, term && (b == nbeats - 1), ac);
            if (kind == 0 && $urandom_range(0, 2) == 0) begin
                in_data = {$urandom, $urandom, $urandom, $urandom};
                in_last = 1'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                in_last = 1'b0;
            end
        end
        if (term) exp_q.push_back('{use_lit ? lit : ones_fold(s), ac});
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_csum", out_csum, 0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_out", out_valid, 1);
    endtask

    initial begin
        do_reset(3);

        send_one(128'h0001_0002_0003_0004_0005_0006_0007_0008, 16'hFFFF, 16'hFFDB);
        send_one(128'h0, 16'hFFFF, 16'hFFFF);
        send_one(128'hFFFF_0001_0000_0000_0000_0000_0000_0000, 16'hFFFF, 16'hFFFE);
        send_one(128'h1234_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 16'hC000, 16'hEDCB);

        drain();
        hold_lo = 1'b1;
        send_pkt(1, 0, 16'($urandom), 1'b1, 1'b0, 16'h0);
        wait_out();
        repeat (10) @(posedge clk);
        #1;
        hold_lo = 1'b0;
        drain();

        send_pkt(3, 0, 16'($urandom), 1'b0, 1'b0, 16'h0);
        do_reset(2);
        send_pkt(5, 0, 16'($urandom), 1'b1, 1'b0, 16'h0);

        drain();
        hold_lo = 1'b1;
        send_pkt(2, 0, 16'($urandom), 1'b1, 1'b0, 16'h0);
        wait_out();
        repeat (3) @(posedge clk);
        #1;
        void'(exp_q.pop_back());
        do_reset(2);
        hold_lo = 1'b0;

        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 12), 0, 16'($urandom), 1'b1, 1'b0, 16'h0);
        end

        send_pkt(4096, 1, 16'h0000, 1'b1, 1'b1, 16'h0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csum_accum.md
CSUM_ACCUM -- requirements
Module: csum_accum

Interface
REQ-001 Parameter MAX_BEATS, default 4096, maximum number of beats per packet for which the result is guaranteed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream beat valid.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_data  input  128  eight 16-bit words in network order; word0 = in_data[127:112].
REQ-007 in_keep  input  16  byte enables; bit15 maps to in_data[127:120].
REQ-008 in_last  input  1  final beat of packet.
REQ-009 out_valid  output  1  checksum available.
REQ-010 out_ready  input  1  downstream accepts checksum.
REQ-011 out_csum  output  16  16-bit ones-complement Internet checksum of the packet.

Function
REQ-012 A beat SHALL be accepted in a cycle when in_valid and in_ready are both high; disabled bytes SHALL count as zero.
REQ-013 Stage S1 SHALL compress the 8 masked words, zero-extended to 32 bits, into a registered sum/carry pair using 4:2 carry-save compression, with no carry-propagate adder.
REQ-014 Stage S2 SHALL merge the S1 pair into a 32-bit carry-save accumulator (acc_sum, acc_carry) using one 4:2 compression per beat, dropping the carry out of bit 31.
REQ-015 FSM states SHALL be ACC -> DRAIN -> CPA -> FOLD -> OUT -> ACC.
  - ACC: in_ready=1.
  - Accepting in_last SHALL move the FSM to DRAIN.
  - DRAIN, CPA and FOLD SHALL each last exactly one cycle.
  - OUT SHALL hold until out_ready is high.
REQ-016 CPA SHALL register s = acc_sum + (acc_carry<<1) mod 2^32; FOLD SHALL compute f1 = s[31:16] + s[15:0], then f2 = f1[15:0] + f1[16], and register out_csum = ~f2.
REQ-017 When in_last is accepted in cycle N, out_valid SHALL be high from cycle N+4; in_ready SHALL be 0 from N+1 until the output handshake.
REQ-018 While out_valid=1 and out_ready=0, out_valid and out_csum SHALL stay stable.
REQ-019 On the output handshake, the accumulator and S1 SHALL clear, and in_ready SHALL return to 1 in the next cycle.
REQ-020 A packet of one beat (in_last on the first beat) SHALL be legal; in_valid=0 bubbles within a packet SHALL not alter the accumulator.
REQ-021 Packets of at most MAX_BEATS beats SHALL give exact results; longer packets SHALL give an undefined out_csum but the handshake protocol SHALL still be obeyed.

Reset
REQ-022 While reset is high, the block SHALL hold:
  - FSM=ACC
  - accumulator, S1 and out_csum = 0
  - out_valid=0
  - in_ready=0
REQ-023 The first cycle after reset deasserts SHALL have in_ready=1.
REQ-024 A reset mid-packet or in OUT SHALL discard all partial state; no checksum SHALL be emitted for the interrupted packet.

Configuration
REQ-025 With CSUM_ACCUM_SEED_EN defined, input in_seed[15:0] SHALL exist and SHALL be added as a ninth word on the first beat of each packet (pseudo-header seed).
REQ-026 Without CSUM_ACCUM_SEED_EN, the port SHALL be absent and the accumulator SHALL start from zero.

Structure
REQ-027 Package csum_pkg SHALL hold:
  - FSM state enum
  - CSUM_WORDS=8
  - MAX_BEATS default
  - fold width constants
REQ-028 The compression tree SHALL instantiate the existing csa_32x4 compressor (3 in S1, 1 in S2).
REQ-029 One new sub-module csum_fold SHALL implement the CPA and the end-around fold.

Verification
REQ-030 One beat, keep=FFFF, words 0x0001..0x0008 in cycle N -> out_csum=0xFFDB, out_valid high at N+4.
REQ-031 One beat of all-zero data -> out_csum=0xFFFF.
REQ-032 One beat, word0=0xFFFF, word1=0x0001, others 0 -> end-around carry folds -> out_csum=0xFFFE.
REQ-033 in_keep=16'hC000, in_data top bytes 0x1234, all other bytes 0xFF -> out_csum=0xEDCB.
REQ-034 out_ready held low 10 cycles -> out_valid/out_csum stable, in_ready=0; then a mid-packet reset -> no output, next packet correct.
REQ-035 4096 beats of all 0xFF bytes (sum 0x7FFF8000) -> out_csum=0x0000.
